// File: rtl/vend_dispenser_if.sv
// rtl/vend_dispenser_if.sv - vend request, motor, coin hopper and stock signals of the dispenser
// Optional SALES_COUNT_EN adds the sold_total counter output.
interface vend_dispenser_if;
    logic [1:0] product;
    logic [3:0] change;
    logic       motor_done;
    logic       hopper_ack;
    logic       restock;
    logic [1:0] restock_item;
    logic [5:0] left1;
    logic [5:0] left2;
    logic [5:0] left3;
    logic [2:0] motor;
    logic       coin5_out;
    logic       coin1_out;
    logic       busy;
    logic       empty_err;
    logic       jam_err;
`ifdef SALES_COUNT_EN
    logic [7:0] sold_total;
`endif

    modport slave (
        input  product, change, motor_done, hopper_ack, restock, restock_item,
        output left1, left2, left3, motor, coin5_out, coin1_out, busy, empty_err, jam_err
`ifdef SALES_COUNT_EN
        , output sold_total
`endif
    );

    modport master (
        output product, change, motor_done, hopper_ack, restock, restock_item,
        input  left1, left2, left3, motor, coin5_out, coin1_out, busy, empty_err, jam_err
`ifdef SALES_COUNT_EN
        , input sold_total
`endif
    );
endinterface

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - three-item spiral dispenser with timed motor drive and greedy 5/1 coin payout
// Optional SALES_COUNT_EN adds a saturating sold_total counter of successful dispenses.
module vend_dispenser #(
    parameter int unsigned STOCK_INIT    = 32,
    parameter int unsigned MOTOR_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    vend_dispenser_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_PAYOUT   = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int unsigned TW         = (MOTOR_TIMEOUT > 1) ? $clog2(MOTOR_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MOTOR_TIMEOUT - 1);
    localparam logic [5:0] STOCK_FULL  = 6'(STOCK_INIT);

    logic [1:0]      state;
    logic [1:0]      item_q;
    logic [3:0]      rem_q;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0][5:0] stock;
    logic [2:0]      motor_q;
    logic            coin5_q;
    logic            coin1_q;
    logic            empty_q;
    logic            jam_q;

    logic            req_valid;
    logic            restock_hit;
    logic [5:0]      avail;
    logic [2:0]      motor_sel;

    assign req_valid   = (bus.product != 2'd0) || (bus.change != 4'd0);
    assign restock_hit = bus.restock && (bus.restock_item != 2'd0);

    // Stock seen by a new request already includes a same-cycle restock of that item.
    always_comb begin
        avail     = 6'd0;
        motor_sel = 3'b000;
        case (bus.product)
            2'd1: begin avail = stock[0]; motor_sel = 3'b001; end
            2'd2: begin avail = stock[1]; motor_sel = 3'b010; end
            2'd3: begin avail = stock[2]; motor_sel = 3'b100; end
            default: begin avail = 6'd0; motor_sel = 3'b000; end
        endcase
        if (restock_hit && (bus.restock_item == bus.product)) begin
            avail = STOCK_FULL;
        end
    end

`ifdef SALES_COUNT_EN
    logic [7:0] sold_q;
    assign bus.sold_total = sold_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            item_q  <= 2'd0;
            rem_q   <= 4'd0;
            tmo_cnt <= '0;
            stock   <= {STOCK_FULL, STOCK_FULL, STOCK_FULL};
            motor_q <= 3'b000;
            coin5_q <= 1'b0;
            coin1_q <= 1'b0;
            empty_q <= 1'b0;
            jam_q   <= 1'b0;
`ifdef SALES_COUNT_EN
            sold_q  <= 8'd0;
`endif
        end else begin
            empty_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (restock_hit) begin
                        for (int i = 0; i < 3; i++) begin
                            if (bus.restock_item == 2'(i + 1)) begin
                                stock[i] <= STOCK_FULL;
                            end
                        end
                    end
                    if (req_valid) begin
                        item_q <= bus.product;
                        rem_q  <= bus.change;
                        if (bus.product != 2'd0) begin
                            state   <= ST_DISPENSE;
                            tmo_cnt <= '0;
                            if (avail == 6'd0) begin
                                empty_q <= 1'b1;
                            end else begin
                                motor_q <= motor_sel;
                            end
                        end else begin
                            state <= ST_PAYOUT;
                        end
                    end
                end

                ST_DISPENSE: begin
                    // A motor left idle on entry marks the out-of-stock pass-through.
                    if (motor_q == 3'b000) begin
                        state <= ST_PAYOUT;
                    end else if (bus.motor_done) begin
                        motor_q <= 3'b000;
                        state   <= ST_PAYOUT;
                        for (int i = 0; i < 3; i++) begin
                            if ((item_q == 2'(i + 1)) && (stock[i] != 6'd0)) begin
                                stock[i] <= stock[i] - 6'd1;
                            end
                        end
`ifdef SALES_COUNT_EN
                        if (sold_q != 8'hFF) begin
                            sold_q <= sold_q + 8'd1;
                        end
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        motor_q <= 3'b000;
                        jam_q   <= 1'b1;
                        state   <= ST_PAYOUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_PAYOUT: begin
                    // A coin is only requested from a cycle with no request high,
                    // which guarantees the low gap after every acknowledge.
                    if (coin5_q) begin
                        if (bus.hopper_ack) begin
                            coin5_q <= 1'b0;
                            rem_q   <= rem_q - 4'd5;
                        end
                    end else if (coin1_q) begin
                        if (bus.hopper_ack) begin
                            coin1_q <= 1'b0;
                            rem_q   <= rem_q - 4'd1;
                        end
                    end else if (rem_q >= 4'd5) begin
                        coin5_q <= 1'b1;
                    end else if (rem_q != 4'd0) begin
                        coin1_q <= 1'b1;
                    end else begin
                        state <= ST_DONE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.left1     = stock[0];
    assign bus.left2     = stock[1];
    assign bus.left3     = stock[2];
    assign bus.motor     = motor_q;
    assign bus.coin5_out = coin5_q;
    assign bus.coin1_out = coin1_q;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.empty_err = empty_q;
    assign bus.jam_err   = jam_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - directed self-checking bench for vend_dispenser
module tb_vend_dispenser;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   coin_code;
    bit   overlap;
    bit   timed_out;

    vend_dispenser_if bus();

    vend_dispenser #(.STOCK_INIT(32), .MOTOR_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acknowledges every coin request until busy drops; coins are encoded as decimal digits in order.
    task automatic collect_payout(input int budget);
        bit p5;
        bit p1;
        p5 = 1'b0;
        p1 = 1'b0;
        coin_code = 0;
        overlap = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (bus.coin5_out && bus.coin1_out) overlap = 1'b1;
            if (bus.coin5_out && !p5) coin_code = coin_code * 10 + 5;
            if (bus.coin1_out && !p1) coin_code = coin_code * 10 + 1;
            p5 = bus.coin5_out;
            p1 = bus.coin1_out;
            bus.hopper_ack = bus.coin5_out | bus.coin1_out;
            if (!bus.busy) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        bus.hopper_ack = 1'b0;
    endtask

    task automatic do_vend(input logic [1:0] item, input logic [3:0] chg);
        bus.product = item;
        bus.change = chg;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        collect_payout(60);
    endtask

    task automatic test_reset();
        tick();
        total++; if (bus.left1 !== 6'd32 || bus.left2 !== 6'd32 || bus.left3 !== 6'd32) begin bad++; $display("FAIL reset_left left=%0d/%0d/%0d want 32", bus.left1, bus.left2, bus.left3); end
        total++; if ({bus.motor, bus.coin5_out, bus.coin1_out, bus.busy, bus.empty_err, bus.jam_err} !== 8'd0) begin bad++; $display("FAIL reset_outputs motor=%b c5=%b c1=%b busy=%b empty=%b jam=%b want all 0", bus.motor, bus.coin5_out, bus.coin1_out, bus.busy, bus.empty_err, bus.jam_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vend_plain();
        int on_cnt;
        on_cnt = 0;
        bus.product = 2'd1;
        tick();
        bus.product = 2'd0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL vend1_busy got=%b want 1", bus.busy); end
        for (int c = 0; c < 3; c++) begin
            if (bus.motor === 3'b001) on_cnt++;
            if (c == 2) bus.motor_done = 1'b1;
            tick();
        end
        bus.motor_done = 1'b0;
        total++; if (on_cnt !== 3) begin bad++; $display("FAIL vend1_motor_cycles got=%0d want 3", on_cnt); end
        total++; if (bus.motor !== 3'b000) begin bad++; $display("FAIL vend1_motor_drop got=%b want 000", bus.motor); end
        total++; if (bus.left1 !== 6'd31) begin bad++; $display("FAIL vend1_left1 got=%0d want 31", bus.left1); end
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL vend1_busy_done got=%b want 1", bus.busy); end
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL vend1_busy_fall got=%b want 0", bus.busy); end
    endtask

    task automatic test_change();
        bus.product = 2'd2;
        bus.change = 4'd7;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        total++; if (bus.motor !== 3'b010) begin bad++; $display("FAIL chg_motor got=%b want 010", bus.motor); end
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        total++; if (bus.left2 !== 6'd31) begin bad++; $display("FAIL chg_left2 got=%0d want 31", bus.left2); end
        collect_payout(60);
        total++; if (timed_out || coin_code !== 511) begin bad++; $display("FAIL chg_coins got=%0d timeout=%b want 511", coin_code, timed_out); end
        total++; if (overlap) begin bad++; $display("FAIL chg_one_coin got=overlap want exclusive"); end
        total++; if (dut.rem_q !== 4'd0) begin bad++; $display("FAIL chg_rem got=%0d want 0", dut.rem_q); end
    endtask

    task automatic test_jam();
        int on_cnt;
        on_cnt = 0;
        bus.product = 2'd3;
        bus.change = 4'd2;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        while (bus.motor === 3'b100 && on_cnt < 30) begin
            on_cnt++;
            tick();
        end
        total++; if (on_cnt !== 15) begin bad++; $display("FAIL jam_motor_cycles got=%0d want 15", on_cnt); end
        total++; if (bus.jam_err !== 1'b1) begin bad++; $display("FAIL jam_flag got=%b want 1", bus.jam_err); end
        total++; if (bus.left3 !== 6'd32) begin bad++; $display("FAIL jam_left3 got=%0d want 32", bus.left3); end
        collect_payout(60);
        total++; if (timed_out || coin_code !== 11) begin bad++; $display("FAIL jam_payout got=%0d timeout=%b want 11", coin_code, timed_out); end
        tick();
        total++; if (bus.jam_err !== 1'b1) begin bad++; $display("FAIL jam_sticky got=%b want 1", bus.jam_err); end
    endtask

    task automatic test_empty();
        int pulses;
        bit moved;
        pulses = 0;
        moved = 1'b0;
        for (int v = 0; v < 31; v++) do_vend(2'd1, 4'd0);
        total++; if (bus.left1 !== 6'd0) begin bad++; $display("FAIL empty_drain got=%0d want 0", bus.left1); end
        bus.product = 2'd1;
        bus.change = 4'd3;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        for (int c = 0; c < 3; c++) begin
            if (bus.empty_err === 1'b1) pulses++;
            if (bus.motor !== 3'b000) moved = 1'b1;
            tick();
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL empty_pulse got=%0d want 1", pulses); end
        total++; if (moved) begin bad++; $display("FAIL empty_motor got=moved want 000"); end
        collect_payout(60);
        total++; if (timed_out || coin_code !== 111) begin bad++; $display("FAIL empty_payout got=%0d timeout=%b want 111", coin_code, timed_out); end
        total++; if (bus.left1 !== 6'd0) begin bad++; $display("FAIL empty_saturate got=%0d want 0", bus.left1); end
    endtask

    task automatic test_busy_restock();
        bus.product = 2'd2;
        tick();
        bus.product = 2'd1;
        bus.change = 4'd5;
        bus.restock = 1'b1;
        bus.restock_item = 2'd1;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        bus.restock = 1'b0;
        bus.restock_item = 2'd0;
        total++; if (bus.left1 !== 6'd0) begin bad++; $display("FAIL busy_restock_ignored got=%0d want 0", bus.left1); end
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        collect_payout(60);
        total++; if (timed_out || coin_code !== 0) begin bad++; $display("FAIL busy_req_ignored coins=%0d timeout=%b want 0", coin_code, timed_out); end
        total++; if (bus.left2 !== 6'd30) begin bad++; $display("FAIL busy_left2 got=%0d want 30", bus.left2); end
        bus.motor_done = 1'b1;
        bus.hopper_ack = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        bus.hopper_ack = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.left2 !== 6'd30) begin bad++; $display("FAIL idle_strobes busy=%b left2=%0d want 0/30", bus.busy, bus.left2); end
        bus.restock = 1'b1;
        bus.restock_item = 2'd1;
        tick();
        bus.restock = 1'b0;
        bus.restock_item = 2'd0;
        total++; if (bus.left1 !== 6'd32 || bus.busy !== 1'b0) begin bad++; $display("FAIL restock_left1 got=%0d busy=%b want 32/0", bus.left1, bus.busy); end
    endtask

    task automatic test_restock_vend();
        bus.restock = 1'b1;
        bus.restock_item = 2'd2;
        bus.product = 2'd2;
        tick();
        bus.restock = 1'b0;
        bus.restock_item = 2'd0;
        bus.product = 2'd0;
        total++; if (bus.motor !== 3'b010 || bus.left2 !== 6'd32) begin bad++; $display("FAIL rsv_start motor=%b left2=%0d want 010/32", bus.motor, bus.left2); end
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        total++; if (bus.left2 !== 6'd31) begin bad++; $display("FAIL rsv_left2 got=%0d want 31", bus.left2); end
        collect_payout(60);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        bus.product = 2'd2;
        bus.change = 4'd9;
        tick();
        bus.product = 2'd0;
        bus.change = 4'd0;
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.coin5_out === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_coin5 got=0 want 1 before reset"); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.motor, bus.coin5_out, bus.coin1_out, bus.busy, bus.empty_err, bus.jam_err} !== 8'd0) begin bad++; $display("FAIL rstmid_outputs motor=%b c5=%b c1=%b busy=%b empty=%b jam=%b want all 0", bus.motor, bus.coin5_out, bus.coin1_out, bus.busy, bus.empty_err, bus.jam_err); end
        total++; if (bus.left1 !== 6'd32 || bus.left2 !== 6'd32 || bus.left3 !== 6'd32) begin bad++; $display("FAIL rstmid_left left=%0d/%0d/%0d want 32", bus.left1, bus.left2, bus.left3); end
        total++; if (dut.rem_q !== 4'd0 || dut.item_q !== 2'd0) begin bad++; $display("FAIL rstmid_regs rem=%0d item=%0d want 0/0", dut.rem_q, dut.item_q); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        total++; if (bus.busy !== 1'b0 || bus.coin5_out !== 1'b0 || bus.coin1_out !== 1'b0) begin bad++; $display("FAIL rstmid_after busy=%b c5=%b c1=%b want 0", bus.busy, bus.coin5_out, bus.coin1_out); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.product = 2'd0;
        bus.change = 4'd0;
        bus.motor_done = 1'b0;
        bus.hopper_ack = 1'b0;
        bus.restock = 1'b0;
        bus.restock_item = 2'd0;
        test_reset();
        test_vend_plain();
        test_change();
        test_jam();
        test_empty();
        test_busy_restock();
        test_restock_vend();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 Parameters: STOCK_INIT = 32, initial count per item; MOTOR_TIMEOUT = 15, maximum cycles to wait for motor_done.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 product  input  2  one-cycle vend request: 00 none, 01/10/11 item 1/2/3.
REQ-005 change  input  4  one-cycle change amount in coin units, 0..15, sampled with product.
REQ-006 motor_done  input  1  spiral motor finished one dispense.
REQ-007 hopper_ack  input  1  hopper ejected the currently requested coin.
REQ-008 restock  input  1  one-cycle pulse that refills the item selected by restock_item.
REQ-009 restock_item  input  2  item to refill: 01/10/11; 00 means no item.
REQ-010 left1, left2, left3  output  6 each  remaining stock, fed to the vending controller.
REQ-011 motor  output  3  one-hot motor drive: bit0 item 1, bit1 item 2, bit2 item 3.
REQ-012 coin5_out, coin1_out  output  1 each  request one 5-unit or one 1-unit coin.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 empty_err  output  1  one-cycle pulse when the requested item has stock 0.
REQ-015 jam_err  output  1  sticky motor-timeout flag.

Function
REQ-016 States are IDLE, DISPENSE, PAYOUT and DONE; state is registered and changes only on the clk edge.
REQ-017 In IDLE, if product!=00 or change!=0, the block SHALL capture product into item_q and change into rem_q in that cycle.
- If product!=00, next state is DISPENSE.
- Otherwise, next state is PAYOUT.
REQ-018 Requests arriving while busy=1 SHALL be ignored and not queued.
REQ-019 Entering DISPENSE with stock of item_q = 0:
- motor stays 0;
- empty_err pulses for exactly one cycle;
- next state is PAYOUT;
- stock is unchanged.
REQ-020 Entering DISPENSE with stock > 0:
- the motor bit for item_q goes high from the first DISPENSE cycle;
- it stays high until motor_done=1 is sampled.
- On that sample: the motor bit drops, the item's left count decrements by 1, and next state is PAYOUT.
REQ-021 If motor_done is not seen within MOTOR_TIMEOUT cycles of DISPENSE:
- the motor drops;
- jam_err sets and stays set;
- stock does not change;
- next state is PAYOUT.
REQ-022 PAYOUT uses greedy coin selection:
- if rem_q >= 5, assert coin5_out; otherwise, if rem_q > 0, assert coin1_out;
- at most one coin request is high at a time;
- the request holds until hopper_ack is sampled, then rem_q decreases by 5 or 1 and the request drops for at least one cycle.
REQ-023 When rem_q = 0, PAYOUT SHALL go to DONE; DONE lasts one cycle and then returns to IDLE.
REQ-024 Stock counts SHALL saturate at 0 and never wrap.
REQ-025 restock=1 in IDLE with restock_item != 00 SHALL load STOCK_INIT into the selected left count.
- restock while busy is ignored.
- restock_item 00 is ignored.
REQ-026 restock and a vend request in the same IDLE cycle: restock is applied first, and the vend request is still captured.
REQ-027 motor_done or hopper_ack outside their wait states SHALL be ignored.

Reset
REQ-028 rst=1 SHALL immediately force the following, regardless of clk:
- state to IDLE;
- left1, left2 and left3 to STOCK_INIT;
- motor to 000;
- coin5_out, coin1_out, busy, empty_err and jam_err to 0;
- item_q and rem_q to 0.
REQ-029 Reset during DISPENSE or PAYOUT SHALL abandon the transaction with no stock decrement and no further coin requests.

Configuration
REQ-030 With SALES_COUNT_EN defined, the block SHALL add output sold_total (8 bits, reset 0).
- It increments on each successful dispense (REQ-020).
- It saturates at 255.
REQ-031 Without SALES_COUNT_EN, the port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 product=01, change=0, motor_done 3 cycles later -> motor=001 for 3 cycles; left1 goes 32 to 31; busy falls 2 cycles after motor_done.
REQ-033 product=10, change=7, motor_done and every hopper_ack given -> coin sequence coin5, coin1, coin1; left2=31; rem_q ends at 0.
REQ-034 product=11, motor_done never asserted -> motor drops after 15 cycles; jam_err=1 and stays 1; left3 stays 32; payout still runs.
REQ-035 Drain left1 to 0, then request product=01 with change=3 -> empty_err pulses once; motor stays 000; three coin1 requests follow.
REQ-036 Second request while busy, then restock of item 01 in IDLE -> second request is ignored; left1 returns to 32.
REQ-037 rst asserted mid-PAYOUT -> all outputs clear immediately; left counts read 32.
